// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the cache victim-selection path:
//   - LFSR width and default seed
//   - victim response state enum
//   - first_zero(): lowest zero index of a (up to 16-bit) valid mask
// Callers with fewer than 16 ways pad the unused upper mask bits with ones
// so they are never reported as the first zero.
// ---------------------------------------------------------------------------
package cache_pkg;

  localparam int              LFSR_W        = 12;
  localparam logic [11:0]     LFSR_SEED_DEF = 12'h528;
  localparam int              MAX_WAYS      = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } victim_state_e;

  // Returns the index of the lowest zero bit; 0 when the mask is all ones.
  function automatic logic [3:0] first_zero(input logic [MAX_WAYS-1:0] mask);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (!mask[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/cache_lfsr.sv
// ---------------------------------------------------------------------------
// cache_lfsr
// Free-running 12-bit right-shifting LFSR used as the random way source.
// Advances every clock regardless of traffic; next = {x[0]^x[1], x[11:1]}.
// Ports:
//   clk     in   clock
//   rst     in   asynchronous active-high reset (loads SEED)
//   o_state out  current 12-bit LFSR register value
// SEED must be nonzero, otherwise the sequence locks at zero.
// ---------------------------------------------------------------------------
module cache_lfsr
  import cache_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] r_lfsr;

  // LFSR state register, shifts right with feedback into the top bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[0] ^ r_lfsr[1], r_lfsr[LFSR_W-1:1]};
    end
  end

  assign o_state = r_lfsr;

endmodule

// File: rtl/cache_victim_sel.sv
// ---------------------------------------------------------------------------
// cache_victim_sel
// Chooses the refill victim way for a cache miss. The lowest-numbered invalid
// way wins; when every way is valid the upper WAY_LOG bits of a free-running
// LFSR pick the way. One registered response slot with valid/ready on both
// sides; a new request is accepted in the same cycle the old response drains.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   flush                    drop pending response, block accepts this cycle
//   req_valid / req_ready    request handshake
//   req_vmask [WAYS]         valid bits of the indexed set (bit i = way i)
//   resp_valid / resp_ready  response handshake
//   resp_way [WAY_LOG]       chosen victim way
//   resp_inv                 1 = victim was invalid (no writeback needed)
//
// Optional build macro VICTIM_LOCK_EN adds:
//   req_lmask [WAYS]  in    locked ways (never chosen), sampled with req_vmask
//   lock_err          out   sticky; set when a request arrives with all ways
//                           locked, cleared only by reset
// ---------------------------------------------------------------------------
module cache_victim_sel
  import cache_pkg::*;
#(
  parameter int                WAY_LOG   = 1,
  parameter int                WAYS      = 1 << WAY_LOG,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WAYS-1:0]    req_vmask,
`ifdef VICTIM_LOCK_EN
  input  logic [WAYS-1:0]    req_lmask,
  output logic               lock_err,
`endif
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [WAY_LOG-1:0] resp_way,
  output logic               resp_inv
);

  victim_state_e       r_state;
  victim_state_e       w_state_nxt;
  logic [LFSR_W-1:0]   w_lfsr;
  logic                w_accept;
  logic [MAX_WAYS-1:0] w_vpad;
  logic [3:0]          w_pick;
  logic [3:0]          w_sel;
  logic                w_sel_inv;
  logic [WAY_LOG-1:0]  r_way;
  logic                r_inv;
  logic                w_unused_bits;

  cache_lfsr #(
    .SEED    (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .o_state (w_lfsr)
  );

  // Random pick comes from the LFSR register value in the accept cycle.
  assign w_pick = 4'(w_lfsr[LFSR_W-1 -: WAY_LOG]);

  // Only the upper LFSR bits and the low bits of the 4-bit selection are used.
  assign w_unused_bits = ^{w_lfsr, w_sel};

  // flush blocks acceptance outright, even when the slot is draining.
  assign req_ready = !flush && ((r_state == IDLE) || resp_ready);
  assign w_accept  = req_valid && req_ready;

  // Pad the valid mask so ways beyond WAYS look valid to first_zero().
  always_comb begin
    w_vpad            = {MAX_WAYS{1'b1}};
    w_vpad[WAYS-1:0]  = req_vmask;
  end

`ifdef VICTIM_LOCK_EN
  logic [MAX_WAYS-1:0] w_lpad;
  logic [MAX_WAYS-1:0] w_cand;
  logic                w_all_locked;
  logic                r_lock_err;

  // Padded lock mask; a locked way is treated as "valid" for invalid search.
  always_comb begin
    w_lpad            = {MAX_WAYS{1'b0}};
    w_lpad[WAYS-1:0]  = req_lmask;
  end

  assign w_cand       = w_vpad | w_lpad;
  assign w_all_locked = &req_lmask;

  // Victim selection honouring locks; LFSR pick walks upward past locked ways
  always_comb begin
    logic [3:0] idx;
    w_sel     = 4'd0;
    w_sel_inv = 1'b0;
    idx       = 4'd0;
    if (w_all_locked) begin
      w_sel     = 4'd0;
      w_sel_inv = 1'b0;
    end else if (!(&w_cand)) begin
      w_sel     = first_zero(w_cand);
      w_sel_inv = 1'b1;
    end else begin
      // Scan offsets high to low so the smallest offset to an unlocked way wins.
      for (int k = WAYS - 1; k >= 0; k--) begin
        idx = (w_pick + 4'(k)) & 4'(WAYS - 1);
        if (!w_lpad[idx]) begin
          w_sel = idx;
        end else begin
          w_sel = w_sel;
        end
      end
      w_sel_inv = 1'b0;
    end
  end

  // Sticky lock error, only reset clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock_err <= 1'b0;
    end else if (w_accept && w_all_locked) begin
      r_lock_err <= 1'b1;
    end else begin
      r_lock_err <= r_lock_err;
    end
  end

  assign lock_err = r_lock_err;
`else
  // Victim selection: lowest invalid way, otherwise the LFSR pick
  always_comb begin
    w_sel     = 4'd0;
    w_sel_inv = 1'b0;
    if (&w_vpad) begin
      w_sel     = w_pick;
      w_sel_inv = 1'b0;
    end else begin
      w_sel     = first_zero(w_vpad);
      w_sel_inv = 1'b1;
    end
  end
`endif

  // Response state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush overrides both accept and drain
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else if (w_accept) begin
      w_state_nxt = RESP;
    end else if ((r_state == RESP) && resp_ready) begin
      w_state_nxt = IDLE;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Response payload registers, loaded only on accept so they hold under stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_way <= '0;
      r_inv <= 1'b0;
    end else if (w_accept) begin
      r_way <= w_sel[WAY_LOG-1:0];
      r_inv <= w_sel_inv;
    end else begin
      r_way <= r_way;
      r_inv <= r_inv;
    end
  end

  assign resp_valid = (r_state == RESP);
  assign resp_way   = r_way;
  assign resp_inv   = r_inv;

endmodule

// File: doc/cache_victim_sel.md
Name: cache_victim_sel

Overview:
- Consumer side of the cache replacement path: on a miss, decides which way of the indexed set to refill.
- Policy: pick the lowest-numbered invalid way first; if every way is valid, pick a way pseudo-randomly.
- Random source is a free-running 12-bit LFSR, instantiated as a sub-module.
- Sits between the cache miss FSM (requester) and the refill/writeback logic (response consumer). Valid/ready handshake on both sides, one registered response slot.

Parameters:
- WAY_LOG, 1, log2 of associativity; legal range 1..4.
- WAYS, 1<<WAY_LOG, number of ways (derived; never overridden).
- LFSR_SEED, 12'h528, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  drops any pending response
- req_valid  in  1  victim request
- req_ready  out  1  request accepted when req_valid && req_ready
- req_vmask  in  WAYS  valid bits of the indexed set; bit i = way i
- resp_valid  out  1  victim result available
- resp_ready  in  1  consumer takes result when resp_valid && resp_ready
- resp_way  out  WAY_LOG  chosen victim way
- resp_inv  out  1  1 = victim was an invalid way (no writeback needed)

Behaviour:
- Reset (async assert, released synchronously by clk): resp_valid=0, resp_way=0, resp_inv=0, LFSR=LFSR_SEED, state=IDLE.
- LFSR:
  - Advances every clk cycle regardless of traffic.
  - next = {x[0]^x[1], x[11:1]}.
  - Random way = x[11:12-WAY_LOG], taken from the register value in the accept cycle.
- States:
  - IDLE: resp_valid=0.
  - RESP: resp_valid=1, outputs held stable.
- req_ready = (state==IDLE) || resp_ready. Single-entry pipeline; a back-to-back request is accepted in the same cycle the previous response drains.
- Accept in cycle N:
  - resp_valid=1 in cycle N+1 with registered resp_way/resp_inv.
  - Latency is exactly 1 cycle.
- Selection:
  - If req_vmask != all-ones: resp_way = index of lowest 0 bit, resp_inv=1.
  - Else: resp_way = LFSR bits, resp_inv=0.
- Transitions:
  - IDLE→RESP on accept.
  - RESP→IDLE when resp_ready and no new accept.
  - RESP→RESP when resp_ready with a new accept (outputs update).
  - RESP holds while !resp_ready.
- flush:
  - Forces state→IDLE next cycle and forces req_ready=0 in the flush cycle.
  - flush has priority over any accept or drain in the same cycle.
  - The LFSR is unaffected.
- Reset mid-operation: pending response is discarded immediately; the LFSR reloads LFSR_SEED.
- req_vmask is sampled only in the accept cycle; changes at other times have no effect.
- Outputs hold stable while resp_valid && !resp_ready (no combinational path from req_* to resp_*).

Optional Feature:
- Macro: VICTIM_LOCK_EN.
- When defined:
  - Adds input req_lmask [WAYS] (1 = way locked), sampled with req_vmask.
  - Locked ways are never chosen.
  - Invalid search considers only unlocked ways.
  - If every unlocked way is valid: take the LFSR pick; if that way is locked, step upward modulo WAYS to the first unlocked way.
  - If all ways are locked: resp_way=0, resp_inv=0, and sticky output lock_err=1 until reset.
- When undefined: no req_lmask/lock_err ports; all ways are eligible.

Decomposition:
- Shared package cache_pkg:
  - LFSR width constant (12).
  - Default seed.
  - Victim state enum {IDLE, RESP}.
  - Function first_zero(mask) returning the lowest zero index.
- Sub-module: cache_lfsr (clk, rst, seed parameter, 12-bit state output). The top slices the upper WAY_LOG bits.

Test Plan:
- Reset release, WAY_LOG=1, req_valid held from cycle 0, req_vmask=2'b11, resp_ready=1 → accepts in cycles 0,1,2,3 give resp_way (cycle after each) = 0,0,0,1. LFSR values: 0x528, 0x294, 0x14A, 0x8A5.
- WAY_LOG=2, req_vmask=4'b1011 → resp_way=2, resp_inv=1, one cycle later, regardless of LFSR.
- Backpressure:
  - Sequence: accept, then resp_ready=0 for 5 cycles.
  - Required: resp_valid stays 1, resp_way/resp_inv unchanged, req_ready=0.
  - Then resp_ready=1 with a new request pending: new result next cycle, no bubble.
- flush asserted together with req_valid while in RESP → no accept that cycle, resp_valid=0 next cycle.
- Async rst pulse mid-RESP (between clk edges) → resp_valid drops immediately. First post-reset all-valid pick for WAY_LOG=2 is way 1 (0x528 top bits 01).
- VICTIM_LOCK_EN, WAY_LOG=2:
  - req_vmask=4'b1111, lmask=4'b0010, LFSR pick 1 → resp_way=2.
  - lmask=4'b1111 → resp_way=0, lock_err=1, held sticky.
